// File: rtl/poly_sub_seq_pkg.sv
// Shared constants and FSM state type for the sequential polynomial subtractor.
// Q is the modulus used when mod-q correction is enabled.
package poly_sub_seq_pkg;

   localparam int          N      = 256;
   localparam int          COEF_W = 32;
   localparam int          VEC_W  = N * COEF_W;
   localparam logic [31:0] Q      = 32'd8380417;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/coef_sub_lane.sv
// One coefficient subtraction c = a - b, with optional +q correction when the
// difference is negative (operands assumed to lie in [0,q) in that mode).
module coef_sub_lane
   import poly_sub_seq_pkg::*;
#(
   parameter int MODQ = 0
) (
   input  logic [COEF_W-1:0] i_a,
   input  logic [COEF_W-1:0] i_b,
   output logic [COEF_W-1:0] o_c
);

   logic [COEF_W-1:0] w_diff;

   assign w_diff = i_a - i_b;

   generate
      if (MODQ != 0) begin : g_modq
         logic w_neg;
         assign w_neg = ($signed(i_a) < $signed(i_b));
         assign o_c   = w_neg ? (w_diff + Q) : w_diff;
      end else begin : g_plain
         assign o_c = w_diff;
      end
   endgenerate

endmodule

// File: rtl/poly_sub_seq.sv
// Sequential 256-coefficient subtractor: captures both operands on start, then
// writes LANES result coefficients per cycle into the held result register.
module poly_sub_seq
   import poly_sub_seq_pkg::*;
#(
   parameter int LANES = 8,
   parameter int MODQ  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [VEC_W-1:0] linear_a,
   input  logic [VEC_W-1:0] linear_b,
   output logic             busy,
   output logic             done,
   output logic [VEC_W-1:0] linear_c,
   output state_t           dbg_state
);

   localparam int            GROUPS   = N / LANES;
   localparam int            GW       = $clog2(GROUPS);
   localparam int            LW       = LANES * COEF_W;
   localparam int            SW       = $clog2(LW);
   localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

   state_t                 r_state;
   logic [GW-1:0]          r_grp;
   logic [VEC_W-1:0]       r_a;
   logic [VEC_W-1:0]       r_b;
   logic [VEC_W-1:0]       r_c;
   logic                   r_busy;
   logic                   r_done;
   logic [$clog2(VEC_W)-1:0] w_base;
   logic [LW-1:0]          w_a_grp;
   logic [LW-1:0]          w_b_grp;
   logic [LW-1:0]          w_c_grp;

   // LW is a power of two, so the group bit offset is just the counter shifted.
   assign w_base  = {r_grp, {SW{1'b0}}};
   assign w_a_grp = r_a[w_base +: LW];
   assign w_b_grp = r_b[w_base +: LW];

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         coef_sub_lane #(.MODQ(MODQ)) u_lane (
            .i_a (w_a_grp[l*COEF_W +: COEF_W]),
            .i_b (w_b_grp[l*COEF_W +: COEF_W]),
            .o_c (w_c_grp[l*COEF_W +: COEF_W])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grp   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= linear_a;
                  r_b     <= linear_b;
                  r_grp   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_c[w_base +: LW] <= w_c_grp;
               r_grp             <= r_grp + 1'b1;
               if (r_grp == LAST_GRP) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // start seen here is dropped; a new request must arrive in IDLE
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign linear_c  = r_c;
   assign dbg_state = r_state;

endmodule

// File: doc/poly_sub_seq.md
POLY_SUB_SEQ -- requirements
Module: poly_sub_seq

Interface
REQ-001 Parameter LANES, default 8: coefficients processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 Parameter MODQ, default 0: 0 selects plain two's-complement subtraction; 1 selects subtraction reduced mod q = 8380417.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request a subtraction; sampled only in IDLE.
REQ-006 Port linear_a, input, 8192: minuend; 256 signed 32-bit coefficients, coefficient x at bits [32x+31:32x].
REQ-007 Port linear_b, input, 8192: subtrahend; same packing as linear_a.
REQ-008 Port busy, output, 1: high while a subtraction is in progress (RUN state).
REQ-009 Port done, output, 1: one-cycle pulse marking that linear_c is complete.
REQ-010 Port linear_c, output, 8192: registered result, c[x] = a[x] - b[x]; same packing as linear_a.

Function
REQ-011 The FSM shall have three states, IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after the last group, and DONE->IDLE unconditionally.
REQ-012 On start in IDLE, linear_a and linear_b shall be captured into internal registers and the group counter cleared; later input changes shall not affect the result.
REQ-013 In RUN, each cycle shall write coefficients [g*LANES, g*LANES+LANES-1] of linear_c, where g is the group counter, and then increment g.
REQ-014 RUN shall last exactly 256/LANES cycles; done shall be high in the single DONE cycle, 256/LANES+1 cycles after the start edge.
REQ-015 With MODQ=0, each c[x] shall be the low 32 bits of a[x]-b[x], wrapping on overflow (e.g. 0x80000000 - 1 = 0x7FFFFFFF).
REQ-016 With MODQ=1 and both inputs in [0,q), each c[x] = a[x]-b[x]+q when the difference is negative, otherwise a[x]-b[x]; results lie in [0,q). Behaviour for out-of-range inputs is unspecified.
REQ-017 start asserted in RUN or DONE shall be ignored and not queued.
REQ-018 start asserted in the same cycle as done shall be ignored; a new operation needs start in IDLE.
REQ-019 linear_c shall hold its value between operations; groups not yet written in the current operation shall keep their previous values.
REQ-020 busy shall be high exactly in RUN; done exactly in DONE.

Reset
REQ-021 When rst_n is low: state=IDLE, group counter=0, busy=0, done=0, linear_c=0, operand registers=0.
REQ-022 Assertion of rst_n mid-RUN shall abort the operation without a done pulse; after release the block shall accept a fresh start.

Structure
REQ-023 A shared package shall hold N=256, Q=8380417, COEF_W=32 and the state enumeration.
REQ-024 One sub-module, coef_sub_lane, shall perform one coefficient subtraction with optional mod-q correction; it shall be instantiated LANES times.

Verification
REQ-025 LANES=8, MODQ=0, a[x]=x+100, b[x]=x -> every c[x]=100; done 33 cycles after start; busy high for 32 cycles.
REQ-026 MODQ=0, a[0]=0x80000000, b[0]=1, a[1]=0, b[1]=1 -> c[0]=0x7FFFFFFF, c[1]=0xFFFFFFFF.
REQ-027 MODQ=1, a[x]=5, b[x]=7 -> c[x]=8380415; also a[x]=8380416, b[x]=0 -> c[x]=8380416.
REQ-028 start pulsed again mid-RUN with different operands, and again on the done cycle -> exactly one done pulse and a result from the first operands only.
REQ-029 rst_n pulled low at RUN cycle 10 -> outputs zero, no done pulse; after release, a new start completes correctly.
REQ-030 Random operands, LANES in {1,16,64}, 200 runs -> linear_c matches the reference model and latency = 256/LANES+1.
